// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg: shared types and constants for the bit-serial subtractor.
//   state_t        - 3-bit control state, including the decoy states D0..D3
//   DEF_A_MASK/B   - default load-time scramble masks for the operands
//   KEY_* indices  - operand bit positions sampled as key bits by the FSM
package sub_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SUB     = 3'd1,
    ST_DONE    = 3'd2,
    ST_D0      = 3'd3,
    ST_D1      = 3'd4,
    ST_D2      = 3'd5,
    ST_D3      = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_t;

  localparam logic [7:0] DEF_A_MASK = 8'h28;
  localparam logic [7:0] DEF_B_MASK = 8'h1F;

  // Key bit positions on the a/b ports.
  localparam int KEY_A_DECOY = 7;  // IDLE: decoy entry into SUB
  localparam int KEY_A_ABORT = 4;  // SUB: abort to IDLE
  localparam int KEY_A_REENT = 2;  // DONE: re-enter SUB without reload
  localparam int KEY_A_D1    = 1;  // D1/D3: must be 0 to reach DONE / IDLE
  localparam int KEY_B_D0    = 0;  // D0: must be 1 to start subtraction
  localparam int KEY_B_D2    = 2;  // D2: selects IDLE vs D0

endpackage

// File: rtl/serial_sub_bit.sv
// serial_sub_bit: one-bit full subtractor used by the serial datapath.
//   a, b  - minuend / subtrahend bit
//   bin   - incoming borrow
//   diff  - difference bit
//   bout  - outgoing borrow
module serial_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor (a_reg - b_reg, LSB first) behind a
// key-gated control FSM with decoy states.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   en     - start request (inverted when EN_INV = 1)
//   a, b   - operands at load time, key bits afterwards
//   out    - difference shift register
//   borrow - final borrow, 1 when the loaded minuend < subtrahend
//   done   - high while in DONE
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] A_MASK = DEF_A_MASK,
  parameter logic [WIDTH-1:0] B_MASK = DEF_B_MASK,
  parameter bit               EN_INV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic             borrow_reg;
  logic [CW-1:0]    count_reg;

  logic             en_s;
  logic             load;
  logic             diff_bit;
  logic             borrow_next;

  assign en_s = EN_INV ? ~en : en;

  // Operands are (re)loaded only from IDLE or the unreachable decoy D2.
  assign load = en_s && ((state_reg == ST_IDLE) || (state_reg == ST_D2));

  serial_sub_bit u_bit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow_reg),
    .diff (diff_bit),
    .bout (borrow_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Transitions inside each state are in priority order.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (en_s)                  state_next = ST_D0;
        else if (a[KEY_A_DECOY])   state_next = ST_SUB;  // decoy entry, no load
      end
      ST_D0: begin
        state_next = b[KEY_B_D0] ? ST_SUB : ST_IDLE;
      end
      ST_SUB: begin
        if (count_reg == LAST_CNT) state_next = ST_D1;
        else if (a[KEY_A_ABORT])   state_next = ST_IDLE;  // partial result held
      end
      ST_D1: begin
        state_next = a[KEY_A_D1] ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (en_s) state_next = a[KEY_A_REENT] ? ST_SUB : ST_IDLE;
      end
      ST_D2: begin
        state_next = b[KEY_B_D2] ? ST_IDLE : ST_D0;
      end
      ST_D3: begin
        state_next = a[KEY_A_D1] ? ST_D1 : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: load, or one shift/subtract step per SUB cycle, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
    end else if (load) begin
      a_reg      <= a ^ A_MASK;
      b_reg      <= b ^ B_MASK;
      out_reg    <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
    end else if (state_reg == ST_SUB) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      out_reg    <= {diff_bit, out_reg[WIDTH-1:1]};
      borrow_reg <= borrow_next;
      count_reg  <= count_reg + CW'(1);  // wraps to 0 on the last SUB cycle
    end
  end

  assign out    = out_reg;
  assign borrow = borrow_reg;
  assign done   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: self-checking bench for sub_serial. Table vectors and random
// operands are checked against plain modular arithmetic; hand sequences cover
// wrong keys, abort, reset, decoy entry and DONE re-entry.
module tb_sub_serial;
  import sub_serial_pkg::*;

  localparam int         WIDTH  = 8;
  localparam logic [7:0] A_MASK = 8'h28;
  localparam logic [7:0] B_MASK = 8'h1F;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       borrow;
  logic       done;

  int total = 0;
  int bad   = 0;

  sub_serial #(
    .WIDTH  (WIDTH),
    .A_MASK (A_MASK),
    .B_MASK (B_MASK),
    .EN_INV (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pa;   // a port value at load
    logic [7:0] pb;   // b port value at load
    logic [7:0] q;    // expected difference
    logic       bw;   // expected borrow
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; a = '0; b = '0;
    tick();
    rst = 1'b0;
  endtask

  // Reference: plain modular subtraction of the unscrambled operands.
  function automatic logic [8:0] ref_full(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    return {(x < y), d};
  endfunction

  // Reference after k SUB cycles: the low k difference bits sit at the top
  // of out, and the borrow is that of the low k-bit slices.
  function automatic logic [8:0] ref_part(input logic [7:0] x, input logic [7:0] y, input int k);
    int m, d, q;
    m = (1 << k) - 1;
    d = (int'(x) - int'(y)) & m;
    q = (d << (WIDTH - k)) & 8'hFF;
    return {((int'(x) & m) < (int'(y) & m)), q[7:0]};
  endfunction

  // From IDLE: load with en_s = 1 (en = 0).
  task automatic do_load(input logic [7:0] pa, input logic [7:0] pb);
    en = 1'b0; a = pa; b = pb;
    tick();
    en = 1'b1;
    chk("load_state", dut.state_reg, ST_D0);
    chk("load_out", out, 0);
    chk("load_borrow", borrow, 0);
  endtask

  // Full operation with the correct key; leaves the DUT in DONE.
  task automatic run_full(input logic [7:0] pa, input logic [7:0] pb,
                          input logic [7:0] q, input logic bw, input string tag);
    int n;
    do_load(pa, pb);
    a = 8'h00; b = 8'h01;          // b[0]=1 in D0
    tick();
    n = 1;
    chk({tag, "_d0_to_sub"}, dut.state_reg, ST_SUB);
    b = 8'h00;                     // a[4]=0 in SUB, a[1]=0 in D1
    while (!done && n < 40) begin
      tick();
      n++;
    end
    // done first sampled high by the edge WIDTH+3 after the load edge
    chk({tag, "_latency"}, n + 1, WIDTH + 3);
    chk({tag, "_out"}, out, q);
    chk({tag, "_borrow"}, borrow, bw);
    chk({tag, "_done"}, done, 1);
    $display("op %s: a=%02h b=%02h out=%02h borrow=%0d latency=%0d", tag, pa, pb, out, borrow, n + 1);
  endtask

  // DONE -> IDLE via en_s with a[2]=0.
  task automatic go_idle();
    en = 1'b0; a = 8'h00;
    tick();
    en = 1'b1;
    chk("go_idle_state", dut.state_reg, ST_IDLE);
    chk("go_idle_done", done, 0);
  endtask

  // From DONE: re-enter SUB without reload; operands are already shifted out,
  // so the result is 0 - 0 - previous borrow.
  task automatic reenter(input logic prev_bw);
    logic [7:0] q;
    q = 8'h00 - {7'd0, prev_bw};
    en = 1'b0; a = 8'h04;
    tick();
    en = 1'b1; a = 8'h00;
    chk("reent_state", dut.state_reg, ST_SUB);
    chk("reent_cnt0", dut.count_reg, 0);
    for (int i = 1; i <= WIDTH; i++) begin
      tick();
      chk("reent_cnt", dut.count_reg, i % WIDTH);
    end
    chk("reent_d1", dut.state_reg, ST_D1);
    tick();
    chk("reent_done", done, 1);
    chk("reent_out", out, q);
    chk("reent_borrow", borrow, prev_bw);
    // en_s = 0 in DONE: stays in DONE whatever a[2] is
    a = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reent_hold_done", done, 1);
    end
    a = 8'h00;
    $display("reenter: prev_borrow=%0d out=%02h borrow=%0d", prev_bw, out, borrow);
  endtask

  task automatic run_abort(input logic [7:0] x, input logic [7:0] y, input int k);
    logic [8:0] r;
    r = ref_part(x, y, k);
    do_load(x ^ A_MASK, y ^ B_MASK);
    a = 8'h00; b = 8'h01;
    tick();
    b = 8'h00;
    for (int i = 1; i <= k; i++) begin
      if (i == k) a = 8'h10;       // a[4]=1 on the k-th SUB cycle
      tick();
    end
    a = 8'h00;
    chk("abort_state", dut.state_reg, ST_IDLE);
    chk("abort_out", out, r[7:0]);
    chk("abort_borrow", borrow, r[8]);
    chk("abort_cnt", dut.count_reg, k);
    chk("abort_done", done, 0);
    $display("abort: x=%02h y=%02h k=%0d out=%02h borrow=%0d", x, y, k, out, borrow);
  endtask

  initial begin
    logic [7:0] x, y;
    logic [8:0] r;
    int seen;

    // operand ports -> expected (post-mask values noted)
    vecs[0] = '{8'h4C, 8'h3A, 8'h3F, 1'b0};  // 100 - 37
    vecs[1] = '{8'h2D, 8'h16, 8'hFC, 1'b1};  // 5 - 9
    vecs[2] = '{8'h28, 8'h1F, 8'h00, 1'b0};  // 0 - 0
    vecs[3] = '{8'h28, 8'h1E, 8'hFF, 1'b1};  // 0 - 1
    vecs[4] = '{8'hD7, 8'hE0, 8'h00, 1'b0};  // FF - FF
    vecs[5] = '{8'hA8, 8'h60, 8'h01, 1'b0};  // 80 - 7F
    vecs[6] = '{8'h57, 8'h9F, 8'hFF, 1'b1};  // 7F - 80
    vecs[7] = '{8'h28, 8'hE0, 8'h01, 1'b1};  // 00 - FF

    rst = 1'b1; en = 1'b1; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", dut.state_reg, ST_IDLE);
    chk("rst_out", out, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_done", done, 0);
    // en_s = 0 and a[7] = 0: IDLE holds
    tick();
    chk("idle_hold", dut.state_reg, ST_IDLE);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_full(vecs[i].pa, vecs[i].pb, vecs[i].q, vecs[i].bw, $sformatf("vec%0d", i));
      go_idle();
    end

    // DONE re-entry after a non-negative and a negative result
    run_full(8'h4C, 8'h3A, 8'h3F, 1'b0, "pre_reent0");
    reenter(1'b0);
    go_idle();
    run_full(8'h2D, 8'h16, 8'hFC, 1'b1, "pre_reent1");
    reenter(1'b1);
    go_idle();

    // Wrong key in D0: back to IDLE, cleared result, done never rises
    do_load(8'h4C, 8'h3A);
    a = 8'h00; b = 8'h00;
    tick();
    chk("wk_d0_state", dut.state_reg, ST_IDLE);
    chk("wk_d0_out", out, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) seen++;
    end
    chk("wk_d0_done_seen", seen, 0);
    $display("wrong key D0: state=%0d out=%02h", dut.state_reg, out);

    // Wrong key in D1: a[1]=1 sends D1 to IDLE, full result held
    do_load(8'h4C, 8'h3A);
    a = 8'h02; b = 8'h01;
    tick();
    b = 8'h00;
    for (int i = 0; i < WIDTH; i++) tick();
    chk("wk_d1_in_d1", dut.state_reg, ST_D1);
    tick();
    chk("wk_d1_state", dut.state_reg, ST_IDLE);
    chk("wk_d1_done", done, 0);
    chk("wk_d1_out", out, 8'h3F);
    a = 8'h00;
    $display("wrong key D1: state=%0d out=%02h", dut.state_reg, out);

    // Abort on the third SUB cycle (100 - 37)
    run_abort(8'h64, 8'h25, 3);

    // Reset on the fourth SUB cycle
    do_load(8'h4C, 8'h3A);
    a = 8'h00; b = 8'h01;
    tick();
    b = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_in_sub", dut.state_reg, ST_SUB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", dut.state_reg, ST_IDLE);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_borrow", borrow, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", dut.count_reg, 0);
    $display("reset mid-SUB: state=%0d out=%02h", dut.state_reg, out);

    // Decoy entry: IDLE with en_s=0 and a[7]=1 goes to SUB
    en = 1'b1; a = 8'h80;
    tick();
    a = 8'h00;
    chk("decoy_sub", dut.state_reg, ST_SUB);
    $display("decoy entry: state=%0d", dut.state_reg);
    do_reset();

    // Randomised full operations
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      r = ref_full(x, y);
      run_full(x ^ A_MASK, y ^ B_MASK, r[7:0], r[8], $sformatf("rnd%0d", i));
      go_idle();
    end

    // Randomised aborts
    for (int i = 0; i < 15; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      run_abort(x, y, int'($urandom_range(1, WIDTH - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
